// File: rtl/five_stage_dmem_hazard_tracker.sv
// Data-memory access tracker: derives issue/recv stall hazards, captures load data, flags timeouts and stray responses.
// Optional stall-cycle perf counters are built when DMEM_HAZARD_PERF_EN is defined.
module five_stage_dmem_hazard_tracker #(
    parameter int unsigned CORE            = 0,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned SCAN_CYCLES_MIN = 0,
    parameter int unsigned SCAN_CYCLES_MAX = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  dmem_ready,
    input  logic                  dmem_valid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  dmem_req,
    output logic                  d_mem_issue_hazard,
    output logic                  d_mem_recv_hazard,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_data_valid,
    output logic                  timeout_error,
    output logic                  stray_resp_error,
    output logic [31:0]           issue_stall_cycles,
    output logic [31:0]           recv_stall_cycles,
    input  logic                  scan
);

    typedef enum logic {
        IDLE,
        WAIT_RESP
    } state_e;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_e                state_q, state_d;
    logic [15:0]           wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    logic                  load_valid_q, load_valid_d;
    logic                  timeout_q, timeout_d;
    logic                  stray_q, stray_d;
    logic                  access;
    logic                  read_accept;

    always_comb begin
        access             = mem_read | mem_write;
        read_accept        = (state_q == IDLE) & mem_read & dmem_ready;
        state_d            = state_q;
        wait_cnt_d         = wait_cnt_q;
        load_data_d        = load_data_q;
        load_valid_d       = 1'b0;
        timeout_d          = timeout_q;
        stray_d            = stray_q;
        dmem_req           = 1'b0;
        d_mem_issue_hazard = 1'b0;
        d_mem_recv_hazard  = 1'b0;

        case (state_q)
            IDLE: begin
                dmem_req           = access;
                d_mem_issue_hazard = access & ~dmem_ready;
                d_mem_recv_hazard  = read_accept & ~dmem_valid;
                if (read_accept) begin
                    if (dmem_valid) begin
                        load_data_d  = dmem_rdata;
                        load_valid_d = 1'b1;
                    end else begin
                        state_d    = WAIT_RESP;
                        wait_cnt_d = '0;
                    end
                end else if (dmem_valid) begin
                    stray_d = 1'b1;
                end
            end
            WAIT_RESP: begin
                d_mem_recv_hazard = ~dmem_valid;
                if (dmem_valid) begin
                    load_data_d  = dmem_rdata;
                    load_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    // Counter saturates; the sticky flag fires on the cycle it lands on the limit.
                    if (wait_cnt_q != TIMEOUT_LIMIT) begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                    if (wait_cnt_d == TIMEOUT_LIMIT) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            stray_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            timeout_q    <= timeout_d;
            stray_q      <= stray_d;
        end
    end

    assign load_data        = load_data_q;
    assign load_data_valid  = load_valid_q;
    assign timeout_error    = timeout_q;
    assign stray_resp_error = stray_q;

`ifdef DMEM_HAZARD_PERF_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] recv_cnt_q, recv_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q + 32'(d_mem_issue_hazard);
        recv_cnt_d  = recv_cnt_q + 32'(d_mem_recv_hazard);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

    assign issue_stall_cycles = issue_cnt_q;
    assign recv_stall_cycles  = recv_cnt_q;
`else
    assign issue_stall_cycles = '0;
    assign recv_stall_cycles  = '0;
`endif

`ifndef SYNTHESIS
    logic [31:0] cycle_q;
    logic        scan_window;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    // Signed compare keeps a zero lower bound from folding into a constant test.
    always_comb begin
        scan_window = ($signed({1'b0, cycle_q}) >= $signed(33'(SCAN_CYCLES_MIN))) &&
                      ($signed({1'b0, cycle_q}) <= $signed(33'(SCAN_CYCLES_MAX)));
    end

    always_ff @(posedge clock) begin
        if (reset && scan && scan_window) begin
            $display("dmem_trk core=%0d cycle=%0d state=%s issue_hz=%0b recv_hz=%0b req=%0b timeout=%0b stray=%0b",
                     CORE, cycle_q, state_q.name(), d_mem_issue_hazard, d_mem_recv_hazard,
                     dmem_req, timeout_q, stray_q);
        end
    end
`endif

endmodule

// File: tb/tb_five_stage_dmem_hazard_tracker.sv
// Self-checking bench for five_stage_dmem_hazard_tracker: directed scenarios plus randomized traffic against a transaction-level model.
module tb_five_stage_dmem_hazard_tracker;

    localparam int unsigned TO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        dmem_valid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        scan = 1'b0;
    logic        dmem_req;
    logic        d_mem_issue_hazard;
    logic        d_mem_recv_hazard;
    logic [31:0] load_data;
    logic        load_data_valid;
    logic        timeout_error;
    logic        stray_resp_error;
    logic [31:0] issue_stall_cycles;
    logic [31:0] recv_stall_cycles;

    int checks = 0;
    int failures = 0;

    // Transaction-level reference state
    bit          m_pending;
    int unsigned m_waited;
    bit          m_to;
    bit          m_stray;
    bit          m_ldv;
    logic [31:0] m_ld;
    logic [31:0] m_is;
    logic [31:0] m_rs;

    always #5 clock = ~clock;

    five_stage_dmem_hazard_tracker #(
        .CORE(0),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO),
        .SCAN_CYCLES_MIN(0),
        .SCAN_CYCLES_MAX(1000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .dmem_ready(dmem_ready),
        .dmem_valid(dmem_valid),
        .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req),
        .d_mem_issue_hazard(d_mem_issue_hazard),
        .d_mem_recv_hazard(d_mem_recv_hazard),
        .load_data(load_data),
        .load_data_valid(load_data_valid),
        .timeout_error(timeout_error),
        .stray_resp_error(stray_resp_error),
        .issue_stall_cycles(issue_stall_cycles),
        .recv_stall_cycles(recv_stall_cycles),
        .scan(scan)
    );

    function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef DMEM_HAZARD_PERF_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic model_reset();
        m_pending = 0;
        m_waited  = 0;
        m_to      = 0;
        m_stray   = 0;
        m_ldv     = 0;
        m_ld      = '0;
        m_is      = '0;
        m_rs      = '0;
    endtask

    // Apply one cycle of inputs, check every output against the model, then advance the model.
    task automatic cycle(input string tag, input logic rd, input logic wr, input logic rdy,
                         input logic vld, input logic [31:0] data);
        logic e_req, e_ih, e_rh;
        @(negedge clock);
        mem_read   = rd;
        mem_write  = wr;
        dmem_ready = rdy;
        dmem_valid = vld;
        dmem_rdata = data;
        #1;
        if (!m_pending) begin
            e_req = rd | wr;
            e_ih  = (rd | wr) & ~rdy;
            e_rh  = rd & rdy & ~vld;
        end else begin
            e_req = 1'b0;
            e_ih  = 1'b0;
            e_rh  = ~vld;
        end
        checks++;
        if ({dmem_req, d_mem_issue_hazard, d_mem_recv_hazard} !== {e_req, e_ih, e_rh}) begin
            failures++;
            $display("FAIL %s req/issue/recv got=%b exp=%b", tag,
                     {dmem_req, d_mem_issue_hazard, d_mem_recv_hazard}, {e_req, e_ih, e_rh});
        end
        checks++;
        if ({load_data_valid, timeout_error, stray_resp_error} !== {m_ldv, m_to, m_stray}) begin
            failures++;
            $display("FAIL %s ldv/timeout/stray got=%b exp=%b", tag,
                     {load_data_valid, timeout_error, stray_resp_error}, {m_ldv, m_to, m_stray});
        end
        checks++;
        if (load_data !== m_ld) begin
            failures++;
            $display("FAIL %s load_data got=%h exp=%h", tag, load_data, m_ld);
        end
        checks++;
        if ({issue_stall_cycles, recv_stall_cycles} !== {perf_exp(m_is), perf_exp(m_rs)}) begin
            failures++;
            $display("FAIL %s perf got=%0d/%0d exp=%0d/%0d", tag, issue_stall_cycles,
                     recv_stall_cycles, perf_exp(m_is), perf_exp(m_rs));
        end

        m_ldv = 0;
        m_is  = m_is + 32'(e_ih);
        m_rs  = m_rs + 32'(e_rh);
        if (!m_pending) begin
            if (rd && rdy) begin
                if (vld) begin
                    m_ld  = data;
                    m_ldv = 1;
                end else begin
                    m_pending = 1;
                    m_waited  = 0;
                end
            end else if (vld) begin
                m_stray = 1;
            end
        end else if (vld) begin
            m_ld      = data;
            m_ldv     = 1;
            m_pending = 0;
        end else begin
            if (m_waited < TO) m_waited++;
            if (m_waited == TO) m_to = 1;
        end
    endtask

    task automatic reset_dut(input string tag);
        @(negedge clock);
        mem_read   = 0;
        mem_write  = 0;
        dmem_ready = 0;
        dmem_valid = 0;
        dmem_rdata = '0;
        reset      = 0;
        #1;
        checks++;
        if ({dmem_req, d_mem_issue_hazard, d_mem_recv_hazard, load_data_valid, timeout_error,
             stray_resp_error} !== 6'b0 || load_data !== 32'd0 ||
            issue_stall_cycles !== 32'd0 || recv_stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL %s outputs_in_reset got flags=%b ld=%h perf=%0d/%0d exp all zero", tag,
                     {dmem_req, d_mem_issue_hazard, d_mem_recv_hazard, load_data_valid,
                      timeout_error, stray_resp_error}, load_data, issue_stall_cycles,
                     recv_stall_cycles);
        end
        model_reset();
        @(negedge clock);
        reset = 1;
    endtask

    task automatic test_reset();
        reset_dut("reset");
        for (int i = 0; i < 5; i++) cycle("reset_idle", 0, 0, 0, 0, '0);
        @(posedge clock);
        #1;
        checks++;
        if ({dmem_req, d_mem_issue_hazard, d_mem_recv_hazard, load_data_valid, timeout_error,
             stray_resp_error} !== 6'b0 || load_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_idle_outputs got flags=%b ld=%h exp zero",
                     {dmem_req, d_mem_issue_hazard, d_mem_recv_hazard, load_data_valid,
                      timeout_error, stray_resp_error}, load_data);
        end
    endtask

    task automatic test_write_stall();
        int ih_n = 0, req_n = 0, rh_n = 0;
        reset_dut("wstall_rst");
        for (int i = 0; i < 4; i++) begin
            cycle("wstall", 0, 1, (i == 3), 0, '0);
            ih_n  += int'(d_mem_issue_hazard);
            req_n += int'(dmem_req);
            rh_n  += int'(d_mem_recv_hazard);
        end
        @(posedge clock);
        #1;
        checks++;
        if (ih_n != 3 || req_n != 4 || rh_n != 0) begin
            failures++;
            $display("FAIL wstall_counts got issue=%0d req=%0d recv=%0d exp 3/4/0", ih_n, req_n, rh_n);
        end
        checks++;
        if (issue_stall_cycles !== perf_exp(32'd3)) begin
            failures++;
            $display("FAIL wstall_perf got=%0d exp=%0d", issue_stall_cycles, perf_exp(32'd3));
        end
        cycle("wstall_after", 0, 0, 0, 0, '0);
    endtask

    task automatic test_hit();
        reset_dut("hit_rst");
        scan = 1;
        cycle("hit", 1, 0, 1, 1, 32'hDEADBEEF);
        checks++;
        if (d_mem_issue_hazard !== 1'b0 || d_mem_recv_hazard !== 1'b0) begin
            failures++;
            $display("FAIL hit_hazard got=%b%b exp=00", d_mem_issue_hazard, d_mem_recv_hazard);
        end
        @(posedge clock);
        #1;
        scan = 0;
        checks++;
        if (load_data !== 32'hDEADBEEF || load_data_valid !== 1'b1) begin
            failures++;
            $display("FAIL hit_capture got ld=%h v=%b exp ld=deadbeef v=1", load_data, load_data_valid);
        end
        cycle("hit_after", 0, 0, 0, 0, '0);
        @(posedge clock);
        #1;
        checks++;
        if (load_data_valid !== 1'b0 || load_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL hit_pulse got ld=%h v=%b exp ld=deadbeef v=0", load_data, load_data_valid);
        end
    endtask

    task automatic test_miss();
        int rh_n = 0;
        reset_dut("miss_rst");
        cycle("miss_acc", 1, 0, 1, 0, '0);
        rh_n += int'(d_mem_recv_hazard);
        for (int i = 0; i < 3; i++) begin
            cycle("miss_wait", 0, 0, 0, 0, '0);
            rh_n += int'(d_mem_recv_hazard);
        end
        cycle("miss_resp", 0, 0, 0, 1, 32'h12345678);
        checks++;
        if (rh_n != 4 || d_mem_recv_hazard !== 1'b0) begin
            failures++;
            $display("FAIL miss_recv_hz got count=%0d resp_cycle=%b exp 4/0", rh_n, d_mem_recv_hazard);
        end
        @(posedge clock);
        #1;
        checks++;
        if (load_data !== 32'h12345678 || load_data_valid !== 1'b1) begin
            failures++;
            $display("FAIL miss_capture got ld=%h v=%b exp ld=12345678 v=1", load_data, load_data_valid);
        end
        cycle("miss_idle", 1, 0, 1, 1, 32'h0BADF00D);
        checks++;
        if (dmem_req !== 1'b1 || d_mem_recv_hazard !== 1'b0) begin
            failures++;
            $display("FAIL miss_back_idle got req=%b recv=%b exp 1/0", dmem_req, d_mem_recv_hazard);
        end
        cycle("miss_end", 0, 0, 0, 0, '0);
    endtask

    task automatic test_timeout();
        reset_dut("to_rst");
        cycle("to_acc", 1, 0, 1, 0, '0);
        for (int i = 0; i < TO - 1; i++) cycle("to_wait", 0, 0, 0, 0, '0);
        @(posedge clock);
        #1;
        checks++;
        if (timeout_error !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early got=%b exp=0", timeout_error);
        end
        cycle("to_wait_last", 0, 0, 0, 0, '0);
        @(posedge clock);
        #1;
        checks++;
        if (timeout_error !== 1'b1) begin
            failures++;
            $display("FAIL timeout_set got=%b exp=1", timeout_error);
        end
        for (int i = 0; i < 3; i++) cycle("to_hold", 1, 1, 1, 0, '0);
        checks++;
        if (timeout_error !== 1'b1 || d_mem_recv_hazard !== 1'b1 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout_sticky got to=%b recv=%b req=%b exp 1/1/0",
                     timeout_error, d_mem_recv_hazard, dmem_req);
        end
        reset_dut("to_midwait_rst");
        cycle("to_late_resp", 0, 0, 0, 1, 32'hCAFEF00D);
        @(posedge clock);
        #1;
        checks++;
        if (stray_resp_error !== 1'b1 || load_data !== 32'd0 || load_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL late_resp_stray got stray=%b ld=%h v=%b exp 1/0/0",
                     stray_resp_error, load_data, load_data_valid);
        end
    endtask

    task automatic test_stray();
        reset_dut("stray_rst");
        cycle("stray_hit", 1, 0, 1, 1, 32'hAAAA5555);
        cycle("stray_resp", 0, 0, 1, 1, 32'h11111111);
        @(posedge clock);
        #1;
        checks++;
        if (stray_resp_error !== 1'b1 || load_data !== 32'hAAAA5555 || load_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL stray_set got stray=%b ld=%h v=%b exp 1/aaaa5555/0",
                     stray_resp_error, load_data, load_data_valid);
        end
        cycle("stray_wr", 0, 1, 1, 1, 32'h22222222);
        cycle("stray_idle", 0, 0, 0, 0, '0);
        cycle("stray_idle", 0, 0, 0, 0, '0);
        checks++;
        if (stray_resp_error !== 1'b1 || load_data !== 32'hAAAA5555) begin
            failures++;
            $display("FAIL stray_sticky got stray=%b ld=%h exp 1/aaaa5555", stray_resp_error, load_data);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut("b2b_rst");
        cycle("b2b_acc", 1, 0, 1, 0, '0);
        cycle("b2b_resp", 0, 0, 0, 1, 32'hA5A5A5A5);
        cycle("b2b_wr", 0, 1, 1, 0, '0);
        checks++;
        if (dmem_req !== 1'b1 || d_mem_issue_hazard !== 1'b0) begin
            failures++;
            $display("FAIL b2b_issue got req=%b issue=%b exp 1/0", dmem_req, d_mem_issue_hazard);
        end
        cycle("b2b_rd", 1, 0, 1, 0, '0);
        checks++;
        if (d_mem_recv_hazard !== 1'b1) begin
            failures++;
            $display("FAIL b2b_recv got=%b exp=1", d_mem_recv_hazard);
        end
        cycle("b2b_resp2", 1, 1, 1, 1, 32'h5A5A5A5A);
        cycle("b2b_end", 0, 0, 0, 0, '0);
    endtask

    task automatic test_random();
        logic rd, wr, rdy, vld;
        int unsigned kind;
        reset_dut("rand_rst");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 2) begin
                reset_dut("rand_midrst");
            end else begin
                kind = $urandom_range(3);
                rd   = (kind == 1) || (kind == 3);
                wr   = (kind == 2) || (kind == 3);
                rdy  = ($urandom_range(3) != 0);
                if (m_pending)      vld = ($urandom_range(3) == 0);
                else if (rd && rdy) vld = 1'($urandom_range(1));
                else                vld = ($urandom_range(19) == 0);
                cycle("random", rd, wr, rdy, vld, $urandom);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_stall();
        test_hit();
        test_miss();
        test_timeout();
        test_stray();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
